alu_seq: RTL

//   Parametrised successor to the 8-bit ALU: WIDTH-bit ALU with a valid/ready handshake on

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_shifter.sv | 60 ++++++
 rtl/alu_seq.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op encodings, flag bit positions and FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_OP_ADD = 3'd0,
    ALU_OP_SUB = 3'd1,
    ALU_OP_AND = 3'd2,
    ALU_OP_OR  = 3'd3,
    ALU_OP_XOR = 3'd4,
    ALU_OP_SHL = 3'd5,
    ALU_OP_SHR = 3'd6,
    ALU_OP_SRA = 3'd7
  } alu_op_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift(input alu_op_e op);
    return (op == ALU_OP_SHL) || (op == ALU_OP_SHR) || (op == ALU_OP_SRA);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Shift unit for alu_seq: single-bit step, or full barrel shift when ALU_BARREL_SHIFT_EN is defined.
// Both forms return the shifted value and the last bit shifted out.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  alu_op_e                      op,
  input  logic [WIDTH-1:0]             din,
`ifdef ALU_BARREL_SHIFT_EN
  input  logic [$clog2(WIDTH)-1:0]     shamt,
`endif
  output logic [WIDTH-1:0]             dout,
  output logic                         cout
);

`ifdef ALU_BARREL_SHIFT_EN
  localparam int SW = $clog2(WIDTH);

  // Amounts of WIDTH or more only exist for non-power-of-2 widths.
  logic ovr;
  assign ovr = ({1'b0, shamt} >= (SW + 1)'(WIDTH));

  always_comb begin
    dout = din;
    cout = 1'b0;
    case (op)
      ALU_OP_SHL: begin
        if (ovr) {cout, dout} = '0;
        else     {cout, dout} = {1'b0, din} << shamt;
      end
      ALU_OP_SHR: begin
        if (ovr) {dout, cout} = '0;
        else     {dout, cout} = {din, 1'b0} >> shamt;
      end
      ALU_OP_SRA: begin
        if (ovr) begin
          dout = {WIDTH{din[WIDTH-1]}};
          cout = din[WIDTH-1];
        end else begin
          {dout, cout} = $signed({din, 1'b0}) >>> shamt;
        end
      end
      default: ;
    endcase
  end
`else
  always_comb begin
    dout = din;
    cout = 1'b0;
    case (op)
      ALU_OP_SHL: {cout, dout} = {din, 1'b0};
      ALU_OP_SHR: {dout, cout} = {1'b0, din};
      ALU_OP_SRA: {dout, cout} = {din[WIDTH-1], din};
      default: ;
    endcase
  end
`endif

endmodule

// File: rtl/alu_seq.sv
// WIDTH-bit ALU with valid/ready on both sides, registered result/flags, one op in flight.
// Define ALU_BARREL_SHIFT_EN for single-cycle barrel shifts; otherwise shifts iterate one bit per cycle.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH   = 8,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out,
  output logic [3:0]         flags
);

  alu_state_e       state, state_nx;
  alu_op_e          op_in;
  logic             accept;
  logic             go_shift;
  logic             load_res;
  logic [WIDTH-1:0] res_nx;
  logic [3:0]       flags_nx;
  logic [WIDTH-1:0] imm_res;
  logic             imm_c;
  logic             imm_v;
  logic [WIDTH-1:0] sh_dout;
  logic             sh_cout;

  assign op_in     = alu_op_e'(op);
  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;

  // Returns {V, C, result}; C is carry for add and borrow for subtract.
  function automatic logic [WIDTH+1:0] addsub(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic             sub);
    logic signed [WIDTH-1:0] sx;
    logic signed [WIDTH-1:0] sy;
    logic signed [WIDTH:0]   ssum;
    logic        [WIDTH:0]   wide;
    sx   = x;
    sy   = y;
    ssum = sub ? (sx - sy) : (sx + sy);
    wide = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
    return {ssum[WIDTH] ^ ssum[WIDTH-1], wide};
  endfunction

  function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r,
                                          input logic             c,
                                          input logic             v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = (r == '0);
    f[FLAG_N] = r[WIDTH-1];
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

`ifdef ALU_BARREL_SHIFT_EN
  assign go_shift = 1'b0;

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .op    (op_in),
    .din   (a),
    .shamt (shamt),
    .dout  (sh_dout),
    .cout  (sh_cout)
  );
`else
  logic [WIDTH-1:0] sh_p0;
  alu_op_e          op_p0;
  logic [SHAMT_W:0] cnt_p0;
  logic             ovr_p0;
  logic             ovr_in;
  logic             shift_c;

  assign ovr_in   = ({1'b0, shamt} >= (SHAMT_W + 1)'(WIDTH));
  assign go_shift = is_shift(op_in) && (shamt != '0);
  // Oversized logical shifts end with a zero carry; SRA keeps the sign bit it shifted out.
  assign shift_c  = sh_cout && !(ovr_p0 && (op_p0 != ALU_OP_SRA));

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .op   (op_p0),
    .din  (sh_p0),
    .dout (sh_dout),
    .cout (sh_cout)
  );

  // Stage p0: latched shift operand and remaining step count.
  always_ff @(posedge clk) begin
    if (accept) begin
      sh_p0  <= a;
      op_p0  <= op_in;
      cnt_p0 <= ovr_in ? (SHAMT_W + 1)'(WIDTH) : {1'b0, shamt};
      ovr_p0 <= ovr_in;
    end else if (state == ST_SHIFT) begin
      sh_p0  <= sh_dout;
      cnt_p0 <= cnt_p0 - (SHAMT_W + 1)'(1);
    end
  end
`endif

  always_comb begin
    imm_res = a;
    imm_c   = 1'b0;
    imm_v   = 1'b0;
    case (op_in)
      ALU_OP_ADD: {imm_v, imm_c, imm_res} = addsub(a, b, 1'b0);
      ALU_OP_SUB: {imm_v, imm_c, imm_res} = addsub(a, b, 1'b1);
      ALU_OP_AND: imm_res = a & b;
      ALU_OP_OR:  imm_res = a | b;
      ALU_OP_XOR: imm_res = a ^ b;
      default: begin
`ifdef ALU_BARREL_SHIFT_EN
        imm_res = sh_dout;
        imm_c   = sh_cout;
`endif
      end
    endcase
  end

  always_comb begin
    state_nx = state;
    load_res = 1'b0;
    res_nx   = imm_res;
    flags_nx = mk_flags(imm_res, imm_c, imm_v);
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (go_shift) begin
            state_nx = ST_SHIFT;
          end else begin
            load_res = 1'b1;
            state_nx = ST_DONE;
          end
        end else if ((state == ST_DONE) && out_ready) begin
          state_nx = ST_IDLE;
        end
      end
`ifndef ALU_BARREL_SHIFT_EN
      ST_SHIFT: begin
        if (cnt_p0 == (SHAMT_W + 1)'(1)) begin
          load_res = 1'b1;
          res_nx   = sh_dout;
          flags_nx = mk_flags(sh_dout, shift_c, 1'b0);
          state_nx = ST_DONE;
        end
      end
`endif
      default: state_nx = ST_IDLE;
    endcase
  end

  // Stage p1: registered result and flags, held while DONE waits for out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      out   <= '0;
      flags <= '0;
    end else begin
      state <= state_nx;
      if (load_res) begin
        out   <= res_nx;
        flags <= flags_nx;
      end
    end
  end

endmodule
